chacha_stream_ctrl: RTL and testbench

- Sequences one ChaCha encryption job between the SPI slave byte interface and the ChaCha core.
- On a start pulse from the configuration/memory manager it latches a message length and kicks the core.
- It then streams plaintext bytes from SPI RX into the core through an input FIFO, and returns cyphertext to SPI TX through an output FIFO.
- It signals completion once every byte has been returned.

---
 rtl/chacha_ctrl_pkg.sv | 29 ++
 rtl/chacha_stream_ctrl_if.sv | 46 ++++
 rtl/sync_byte_fifo.sv | 57 +++++
 rtl/chacha_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_chacha_stream_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/chacha_ctrl_pkg.sv
// chacha_ctrl_pkg
//   Shared definitions for the ChaCha stream controller slice:
//   state encoding, default sizing parameters and a small state helper.
//   No ports; imported by the interface, the byte FIFO and the top.
package chacha_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned LEN_W_DEF      = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KICK   = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    KICK   = ST_KICK,
    STREAM = ST_STREAM,
    DRAIN  = ST_DRAIN,
    DONE   = ST_DONE
  } ctrl_state_e;

  // Byte traffic between SPI, FIFOs and the core only flows in these states.
  function automatic logic isActive(input ctrl_state_e s);
    return (s == STREAM) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// chacha_stream_ctrl_if
//   Bundles every non-clock signal of the stream controller.
//   Memory manager: i_Start, i_Msg_Len, o_Busy, o_Done, o_Overflow.
//   SPI slave:      i_RX_DV, i_RX_Byte, o_TX_DV, o_TX_Byte, i_TX_Ready.
//   ChaCha core:    o_Core_Start, o_Plaintext/o_Plain_Valid/i_Plain_Ready,
//                   i_Cyphertext/i_Cypher_Valid/o_Cypher_Ready.
//   slave modport is the controller, master modport is its environment.
interface chacha_stream_ctrl_if
  import chacha_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) ();

  logic             i_Start;
  logic [LEN_W-1:0] i_Msg_Len;
  logic             i_RX_DV;
  logic [7:0]       i_RX_Byte;
  logic             o_TX_DV;
  logic [7:0]       o_TX_Byte;
  logic             i_TX_Ready;
  logic             o_Core_Start;
  logic [7:0]       o_Plaintext;
  logic             o_Plain_Valid;
  logic             i_Plain_Ready;
  logic [7:0]       i_Cyphertext;
  logic             i_Cypher_Valid;
  logic             o_Cypher_Ready;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Overflow;

  modport slave (
    input  i_Start, i_Msg_Len, i_RX_DV, i_RX_Byte, i_TX_Ready,
           i_Plain_Ready, i_Cyphertext, i_Cypher_Valid,
    output o_TX_DV, o_TX_Byte, o_Core_Start, o_Plaintext, o_Plain_Valid,
           o_Cypher_Ready, o_Busy, o_Done, o_Overflow
  );

  modport master (
    output i_Start, i_Msg_Len, i_RX_DV, i_RX_Byte, i_TX_Ready,
           i_Plain_Ready, i_Cyphertext, i_Cypher_Valid,
    input  o_TX_DV, o_TX_Byte, o_Core_Start, o_Plaintext, o_Plain_Valid,
           o_Cypher_Ready, o_Busy, o_Done, o_Overflow
  );

endinterface

// File: rtl/sync_byte_fifo.sv
// sync_byte_fifo
//   Single-clock byte FIFO with show-ahead read data.
//   Ports: i_Clk, i_Rst_L (synchronous, active low), wr_en/wr_data push,
//   rd_en pop, rd_data current head, full, empty.
//   DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module sync_byte_fifo
  import chacha_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush, doPop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_data = mem_q[rdPtr_q];

  // A pop on empty is dropped; a push on full is only taken alongside a pop.
  assign doPop  = rd_en && !empty;
  assign doPush = wr_en && (!full || doPop);

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge i_Clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      if (doPush && !doPop)      count_q <= count_q + (AW+1)'(1);
      else if (!doPush && doPop) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/chacha_stream_ctrl.sv
// chacha_stream_ctrl
//   Runs one ChaCha job: latches the length on i_Start, kicks the core,
//   moves SPI RX bytes to the core through an input FIFO and cyphertext
//   back to SPI TX through an output FIFO, then pulses o_Done.
//   Ports: i_Clk, i_Rst_L (synchronous, active low) and the slave side of
//   chacha_stream_ctrl_if carrying all job, SPI and core signals.
module chacha_stream_ctrl
  import chacha_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF
) (
  input logic                 i_Clk,
  input logic                 i_Rst_L,
  chacha_stream_ctrl_if.slave bus
);

  ctrl_state_e      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rxCnt_q, rxCnt_d;
  logic [LEN_W-1:0] txCnt_q, txCnt_d;
  logic             overflow_q, overflow_d;
  logic             txDv_q, txDv_d;
  logic [7:0]       txByte_q, txByte_d;

  logic       active, rxTake, rxAccept, inPop, outPush, txFire;
  logic       inFull, inEmpty, outFull, outEmpty;
  logic [7:0] inHead, outHead;

  assign active  = isActive(state_q);
  assign inPop   = active && !inEmpty && bus.i_Plain_Ready;
  assign outPush = bus.i_Cypher_Valid && bus.o_Cypher_Ready;

  // A wanted RX byte is only counted when the FIFO really takes it, which
  // includes the full-but-popping case.
  assign rxTake   = (state_q == STREAM) && bus.i_RX_DV && (rxCnt_q < len_q);
  assign rxAccept = rxTake && (!inFull || inPop);

  // Requiring txDv_q low spaces TX bytes at least two cycles apart.
  assign txFire = active && !outEmpty && bus.i_TX_Ready && !txDv_q;

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_inFifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .wr_en   (rxTake),
    .wr_data (bus.i_RX_Byte),
    .rd_en   (inPop),
    .rd_data (inHead),
    .full    (inFull),
    .empty   (inEmpty)
  );

  sync_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_outFifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .wr_en   (outPush),
    .wr_data (bus.i_Cyphertext),
    .rd_en   (txFire),
    .rd_data (outHead),
    .full    (outFull),
    .empty   (outEmpty)
  );

  // State and datapath registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rxCnt_q    <= '0;
      txCnt_q    <= '0;
      overflow_q <= 1'b0;
      txDv_q     <= 1'b0;
      txByte_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rxCnt_q    <= rxCnt_d;
      txCnt_q    <= txCnt_d;
      overflow_q <= overflow_d;
      txDv_q     <= txDv_d;
      txByte_q   <= txByte_d;
    end
  end

  // Next-state logic and counter updates.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rxCnt_d    = rxCnt_q;
    txCnt_d    = txCnt_q;
    overflow_d = overflow_q;
    txDv_d     = txFire;
    txByte_d   = txFire ? outHead : txByte_q;

    if (rxAccept)           rxCnt_d    = rxCnt_q + LEN_W'(1);
    if (rxTake && !rxAccept) overflow_d = 1'b1;
    if (txFire)             txCnt_d    = txCnt_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.i_Start) begin
          len_d      = bus.i_Msg_Len;
          rxCnt_d    = '0;
          txCnt_d    = '0;
          overflow_d = 1'b0;
          state_d    = (bus.i_Msg_Len == '0) ? DONE : KICK;
        end
      end
      KICK:    state_d = STREAM;
      STREAM:  if (rxCnt_q == len_q) state_d = DRAIN;
      DRAIN:   if (txCnt_q == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Core-facing outputs are gated to the active states so that every
  // output reads zero straight out of reset.
  assign bus.o_TX_DV        = txDv_q;
  assign bus.o_TX_Byte      = txByte_q;
  assign bus.o_Core_Start   = (state_q == KICK);
  assign bus.o_Plain_Valid  = active && !inEmpty;
  assign bus.o_Plaintext    = (active && !inEmpty) ? inHead : 8'h00;
  assign bus.o_Cypher_Ready = active && !outFull;
  assign bus.o_Busy         = (state_q != IDLE);
  assign bus.o_Done         = (state_q == DONE);
  assign bus.o_Overflow     = overflow_q;

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// tb_chacha_stream_ctrl
//   Self-checking bench for chacha_stream_ctrl. The environment acts as
//   memory manager, SPI slave and a two-deep ChaCha core that returns each
//   plaintext byte XOR 0xFF. Expected TX bytes are the RX bytes the bench
//   sent (those within the job length), XORed with 0xFF, in order.
module tb_chacha_stream_ctrl;
  import chacha_ctrl_pkg::*;

  typedef struct {
    logic [15:0] len;
    int          nRx;
    logic [7:0]  base;
    bit          rnd;
    int          gap;
    int          plainRate;
    int          txRate;
    int          expPulses;
    logic        expOvf;
  } vec_t;

  logic clk;
  logic rstL;

  chacha_stream_ctrl_if #(.LEN_W(16)) bus ();

  chacha_stream_ctrl #(.FIFO_DEPTH(8), .LEN_W(16)) dut (
    .i_Clk   (clk),
    .i_Rst_L (rstL),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cycleNum = 0;
  int coreStartCnt, doneCnt, txPulseCnt, coreStartCyc, doneCyc;
  int plainRate = 100;
  int cyRate    = 100;
  int txRate    = 100;
  bit lastTxReady = 1'b1;
  bit lastTxDv    = 1'b0;
  logic [7:0] coreQ [$];
  logic [7:0] expTx [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hang guard: loops below are all bounded, this only catches a stuck sim.
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {9'h0, bus.o_TX_DV, bus.o_TX_Byte, bus.o_Core_Start, bus.o_Plaintext,
            bus.o_Plain_Valid, bus.o_Cypher_Ready, bus.o_Busy, bus.o_Done,
            bus.o_Overflow};
  endfunction

  // One clock: observe registered outputs after the rising edge, drive the
  // SPI/core environment, then book the core handshakes of the next edge.
  task automatic cycle();
    logic [31:0] expByte;
    @(negedge clk);
    cycleNum++;
    if (!lastTxReady) checkOutput("txDvWithoutReady", bus.o_TX_DV, 0);
    if (lastTxDv)     checkOutput("txDvBackToBack", bus.o_TX_DV, 0);
    if (bus.o_TX_DV) begin
      txPulseCnt++;
      expByte = 32'h100;
      if (expTx.size() > 0) expByte = {24'h0, expTx.pop_front()};
      checkOutput("txByte", bus.o_TX_Byte, expByte);
    end
    lastTxDv = bus.o_TX_DV;
    if (bus.o_Core_Start) begin coreStartCnt++; coreStartCyc = cycleNum; end
    if (bus.o_Done)       begin doneCnt++;      doneCyc      = cycleNum; end

    bus.i_TX_Ready     = ($urandom % 100) < txRate;
    bus.i_Plain_Ready  = (coreQ.size() < 2) && (($urandom % 100) < plainRate);
    bus.i_Cypher_Valid = (coreQ.size() > 0) && (($urandom % 100) < cyRate);
    bus.i_Cyphertext   = (coreQ.size() > 0) ? (coreQ[0] ^ 8'hFF) : 8'h00;
    lastTxReady = bus.i_TX_Ready;
    #1;
    if (bus.i_Cypher_Valid && bus.o_Cypher_Ready) void'(coreQ.pop_front());
    if (bus.o_Plain_Valid && bus.i_Plain_Ready)   coreQ.push_back(bus.o_Plaintext);
  endtask

  task automatic clearCounts();
    coreStartCnt = 0; doneCnt = 0; txPulseCnt = 0;
    coreStartCyc = -1; doneCyc = -1;
  endtask

  task automatic waitDone();
    int budget = 0;
    while (doneCnt == 0 && budget < 3000) begin
      cycle();
      budget++;
    end
    repeat (2) cycle();
  endtask

  task automatic sendRx(input logic [7:0] b, input bit wanted);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    if (wanted) expTx.push_back(b ^ 8'hFF);
    cycle();
    bus.i_RX_DV = 1'b0;
  endtask

  // One complete job described by a table record.
  task automatic applyStimulus(input vec_t v);
    int startCyc;
    logic [7:0] b;
    plainRate = v.plainRate; cyRate = v.plainRate; txRate = v.txRate;
    clearCounts();
    bus.i_Msg_Len = v.len;
    bus.i_Start   = 1'b1;
    startCyc      = cycleNum;
    cycle();
    bus.i_Start = 1'b0;
    for (int i = 0; i < v.nRx; i++) begin
      repeat (v.gap) cycle();
      b = v.rnd ? 8'($urandom) : 8'(v.base + 8'(i));
      sendRx(b, i < int'(v.len));
    end
    waitDone();
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("coreStartCount", coreStartCnt, (v.len != 0) ? 1 : 0);
    if (v.len != 0) checkOutput("coreStartLatency", coreStartCyc, startCyc + 1);
    else            checkOutput("doneLatency", doneCyc, startCyc + 1);
    checkOutput("txPulses", txPulseCnt, v.expPulses);
    checkOutput("overflow", bus.o_Overflow, v.expOvf);
    checkOutput("busyAfterDone", bus.o_Busy, 0);
    checkOutput("txQueueEmpty", expTx.size(), 0);
  endtask

  initial begin
    vec_t vecs [6];
    // len, nRx, base, rnd, gap, plainRate, txRate, expPulses, expOvf
    vecs[0] = '{16'd4,  4,  8'h11, 1'b0, 1, 100, 100, 4,  1'b0};
    vecs[1] = '{16'd0,  0,  8'h00, 1'b0, 1, 100, 100, 0,  1'b0};
    vecs[2] = '{16'd3,  5,  8'h40, 1'b0, 1, 100, 100, 3,  1'b0};
    vecs[3] = '{16'd1,  1,  8'hA5, 1'b0, 2, 100, 100, 1,  1'b0};
    vecs[4] = '{16'd16, 16, 8'h00, 1'b1, 2, 50,  50,  16, 1'b0};
    vecs[5] = '{16'd16, 16, 8'h00, 1'b1, 1, 60,  30,  16, 1'b0};

    bus.i_Start = 1'b0; bus.i_Msg_Len = '0; bus.i_RX_DV = 1'b0; bus.i_RX_Byte = 8'h00;
    bus.i_TX_Ready = 1'b0; bus.i_Plain_Ready = 1'b0; bus.i_Cypher_Valid = 1'b0;
    bus.i_Cyphertext = 8'h00;
    clearCounts();

    rstL = 1'b0;
    repeat (3) cycle();
    checkOutput("resetOutputs", allOutputs(), 0);
    rstL = 1'b1;
    cycle();

    for (int k = 0; k < 6; k++) applyStimulus(vecs[k]);

    // Input FIFO overflow: core holds plaintext ready low while 12 of 20
    // bytes arrive, so only the first 8 are kept.
    plainRate = 0; cyRate = 100; txRate = 100;
    clearCounts();
    bus.i_Msg_Len = 16'd20; bus.i_Start = 1'b1;
    cycle();
    bus.i_Start = 1'b0;
    cycle();
    for (int i = 0; i < 12; i++) sendRx(8'(8'h60 + i), i < 8);
    cycle();
    checkOutput("overflowSet", bus.o_Overflow, 1);
    checkOutput("rxCntAtFull", dut.rxCnt_q, 8);
    checkOutput("noTxWhileStalled", txPulseCnt, 0);
    plainRate = 100;
    for (int i = 0; i < 12; i++) begin
      repeat (3) cycle();
      sendRx(8'(8'h80 + i), 1'b1);
    end
    waitDone();
    checkOutput("ovfDoneCount", doneCnt, 1);
    checkOutput("ovfTxPulses", txPulseCnt, 20);
    checkOutput("overflowHeld", bus.o_Overflow, 1);
    checkOutput("ovfTxQueueEmpty", expTx.size(), 0);
    applyStimulus('{16'd0, 0, 8'h00, 1'b0, 1, 100, 100, 0, 1'b0});

    // Reset in the middle of a 6-byte job after 2 bytes.
    plainRate = 100; cyRate = 100; txRate = 100;
    clearCounts();
    bus.i_Msg_Len = 16'd6; bus.i_Start = 1'b1;
    cycle();
    bus.i_Start = 1'b0;
    cycle();
    sendRx(8'h30, 1'b1);
    sendRx(8'h31, 1'b1);
    rstL = 1'b0;
    cycle();
    checkOutput("midJobResetOutputs", allOutputs(), 0);
    cycle();
    rstL = 1'b1;
    coreQ.delete();
    expTx.delete();
    repeat (4) cycle();
    checkOutput("noDoneAfterReset", doneCnt, 0);
    checkOutput("idleAfterReset", bus.o_Busy, 0);
    applyStimulus('{16'd2, 2, 8'h5A, 1'b0, 1, 100, 100, 2, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
